// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
// cart_pkg : shared types and constants for the Atari 800 cartridge responder
// Revision : 1.0
// ============================================================================
package cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FETCH  = 2'd2,
    ST_DRIVE  = 2'd3
  } cart_state_t;

  localparam logic [12:0] S4_BASE = 13'h0000;
  localparam logic [13:0] S5_BASE = 14'h1000 << 1;
  localparam int          BANK_W  = 2;

endpackage
`default_nettype wire

// File: rtl/cart_rom_bank.sv
`default_nettype none
// ============================================================================
// cart_rom_bank : single-port synchronous-read byte RAM holding the cart image
// Revision      : 1.0
// ============================================================================
module cart_rom_bank #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [0:(2**AW)-1];
  logic [7:0] rdata_q;

  // Contents survive reset, so neither array nor read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cart_responder.sv
`default_nettype none
// ============================================================================
// cart_responder : cartridge end of the Atari 800 slot (S4/S5 ROM, CCTL, RD4/RD5)
// Option macro   : CART_BANKSW_EN (S4 window banked via CCTL, needs ROM_AW>=15)
// Revision       : 1.0
// ============================================================================
module cart_responder
  import cart_pkg::*;
#(
  parameter int ROM_AW = 14,
  parameter int SETTLE = 1
) (
  input  logic              mainClock1,
  input  logic              rst,
  input  logic [12:0]       addr_in,
  input  logic              s4_n,
  input  logic              s5_n,
  input  logic              cctl_n,
  input  logic              rw,
  input  logic              ld_we,
  input  logic [ROM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic              rd4,
  output logic              rd5,
  output logic              sel_err
);

  localparam int              CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [16:0]     SYNC_RST  = {13'd0, 4'b1111};

  // Bus layout: {addr[12:0], s4_n, s5_n, cctl_n, rw}
  logic [16:0] meta_q, sync_q;

  always_ff @(posedge mainClock1) begin
    if (rst) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= {addr_in, s4_n, s5_n, cctl_n, rw};
      sync_q <= meta_q;
    end
  end

  logic [12:0] s_addr;
  logic        s_s4_n, s_s5_n, s_cctl_n, s_rw;
  assign {s_addr, s_s4_n, s_s5_n, s_cctl_n, s_rw} = sync_q;

  cart_state_t       state_q;
  logic [12:0]       addr_q;
  logic              win_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        data_out_q;
  logic              data_oe_q, ld_ack_q, sel_err_q, enabled_q;
  logic [ROM_AW-1:0] rd_addr_d, rom_addr_d;
  logic [7:0]        rom_rdata;

  logic one_sel, both_sel, cctl_wr, sel_ok, ld_en;
  assign one_sel  = s_s4_n ^ s_s5_n;
  assign both_sel = ~s_s4_n & ~s_s5_n;
  assign cctl_wr  = ~s_cctl_n & ~s_rw;
  // A session stays alive only while the same window is held as a read.
  assign sel_ok   = one_sel & s_rw & enabled_q & (~s_s5_n == win_q);
  assign ld_en    = ld_we & (state_q == ST_IDLE);

`ifdef CART_BANKSW_EN
  logic [BANK_W-1:0] bank_q;

  always_ff @(posedge mainClock1) begin
    if (rst) begin
      bank_q <= '0;
    end else if (cctl_wr && !s_addr[3]) begin
      bank_q <= s_addr[BANK_W-1:0];
    end
  end

  always_comb begin
    rd_addr_d       = '0;
    rd_addr_d[14:0] = win_q ? {2'b11, addr_q} : {bank_q, addr_q};
  end
`else
  always_comb begin
    rd_addr_d       = '0;
    rd_addr_d[13:0] = (win_q ? S5_BASE : {1'b0, S4_BASE}) | {1'b0, addr_q};
  end
`endif

  assign rom_addr_d = ld_en ? ld_addr : rd_addr_d;

  cart_rom_bank #(.AW(ROM_AW)) u_rom (
    .clk     (mainClock1),
    .we_i    (ld_en),
    .addr_i  (rom_addr_d),
    .wdata_i (ld_data),
    .rdata_o (rom_rdata)
  );

  always_ff @(posedge mainClock1) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      sel_err_q  <= 1'b0;
      enabled_q  <= 1'b1;
    end else begin
      ld_ack_q <= ld_en;
      if (both_sel) sel_err_q <= 1'b1;
      if (cctl_wr)  enabled_q <= ~s_addr[3];
      case (state_q)
        ST_IDLE: begin
          if (one_sel && s_rw && enabled_q) begin
            state_q <= ST_SETTLE;
            addr_q  <= s_addr;
            win_q   <= ~s_s5_n;
            cnt_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (!sel_ok) begin
            state_q <= ST_IDLE;
          end else if (s_addr != addr_q) begin
            addr_q <= s_addr;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FETCH: begin
          if (!sel_ok) begin
            state_q <= ST_IDLE;
          end else begin
            state_q    <= ST_DRIVE;
            data_out_q <= rom_rdata;
            data_oe_q  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (!sel_ok) begin
            state_q   <= ST_IDLE;
            data_oe_q <= 1'b0;
          end else if (s_addr != addr_q) begin
            state_q   <= ST_SETTLE;
            addr_q    <= s_addr;
            cnt_q     <= '0;
            data_oe_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ld_ack   = ld_ack_q;
  assign sel_err  = sel_err_q;
  assign rd4      = enabled_q;
  assign rd5      = enabled_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_responder.sv
`default_nettype none
// ============================================================================
// tb_cart_responder : directed, scoreboard-based bench for cart_responder
// Revision          : 1.0
// ============================================================================
module tb_cart_responder;

`ifdef CART_BANKSW_EN
  localparam int ROM_AW = 15;
`else
  localparam int ROM_AW = 14;
`endif

  logic              mainClock1 = 1'b0;
  logic              rst = 1'b1;
  logic [12:0]       addr_in = '0;
  logic              s4_n = 1'b1, s5_n = 1'b1, cctl_n = 1'b1, rw = 1'b1;
  logic              ld_we = 1'b0;
  logic [ROM_AW-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic              ld_ack, data_oe, rd4, rd5, sel_err;
  logic [7:0]        data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  cart_responder #(.ROM_AW(ROM_AW), .SETTLE(1)) dut (
    .mainClock1 (mainClock1),
    .rst        (rst),
    .addr_in    (addr_in),
    .s4_n       (s4_n),
    .s5_n       (s5_n),
    .cctl_n     (cctl_n),
    .rw         (rw),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ack     (ld_ack),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .rd4        (rd4),
    .rd5        (rd5),
    .sel_err    (sel_err)
  );

  always #5 mainClock1 = ~mainClock1;

  task automatic tick(input int n);
    repeat (n) @(posedge mainClock1);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_oe(input string tag, input logic lvl, input int maxc);
    int n = 0;
    while (data_oe !== lvl && n < maxc) begin
      tick(1);
      n++;
    end
    check(tag, 16'(data_oe), 16'(lvl));
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'(sb.size()), 16'd1);
    end else begin
      exp = sb.pop_front();
      check(tag, 16'(data_out), 16'(exp));
    end
  endtask

  task automatic load(input logic [ROM_AW-1:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_we = 1'b1;
    tick(1);
    ld_we = 1'b0;
    check("ld_ack_pulse", 16'(ld_ack), 16'd1);
  endtask

  task automatic cctl_write(input logic [12:0] a);
    addr_in = a; cctl_n = 1'b0; rw = 1'b0;
    tick(1);
    cctl_n = 1'b1; rw = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("rst_data_oe",  16'(data_oe),  16'd0);
    check("rst_data_out", 16'(data_out), 16'd0);
    check("rst_ld_ack",   16'(ld_ack),   16'd0);
    check("rst_sel_err",  16'(sel_err),  16'd0);
    check("rst_rd4",      16'(rd4),      16'd1);
    check("rst_rd5",      16'(rd5),      16'd1);
    rst = 1'b0;
    tick(2);

    load(ROM_AW'(16'h0000), 8'hA5);
    load(ROM_AW'(16'h0001), 8'h11);
    load(ROM_AW'(16'h2010), 8'h3C);
`ifdef CART_BANKSW_EN
    load(ROM_AW'(16'h4000), 8'h5A);
`endif
    tick(1);
    check("ld_ack_one_cycle", 16'(ld_ack), 16'd0);

    // S4 read of address 0; nothing may be driven before the synchronisers settle
    addr_in = 13'h0000; rw = 1'b1; s4_n = 1'b0; sb.push_back(8'hA5);
    tick(3);
    check("t1_not_early", 16'(data_oe), 16'd0);
    wait_oe("t1_oe_rise", 1'b1, 4);
    pop_check("t1_data");

    // Loader outside IDLE is dropped without ack
    ld_addr = '0; ld_data = 8'h77; ld_we = 1'b1;
    tick(1);
    ld_we = 1'b0;
    check("drop_no_ack", 16'(ld_ack), 16'd0);

    // Address step while driving
    addr_in = 13'h0001; sb.push_back(8'h11);
    wait_oe("t3_oe_fall", 1'b0, 4);
    check("t3_data_hold", 16'(data_out), 16'hA5);
    wait_oe("t3_oe_rise", 1'b1, 6);
    pop_check("t3_data");
    s4_n = 1'b1;
    wait_oe("t3_release", 1'b0, 3);
    tick(2);

    // S5 window
    addr_in = 13'h0010; s5_n = 1'b0; sb.push_back(8'h3C);
    wait_oe("t2_oe_rise", 1'b1, 8);
    pop_check("t2_data");
    s5_n = 1'b1;
    wait_oe("t2_release", 1'b0, 3);
    tick(2);

    // Host write into S4 is ignored
    addr_in = 13'h0000; rw = 1'b0; s4_n = 1'b0;
    tick(8);
    check("hostwr_no_oe", 16'(data_oe), 16'd0);
    s4_n = 1'b1; rw = 1'b1;
    tick(3);

    // Both selects low
    s4_n = 1'b0; s5_n = 1'b0;
    tick(8);
    check("both_no_oe", 16'(data_oe), 16'd0);
    check("both_sel_err", 16'(sel_err), 16'd1);
    s4_n = 1'b1; s5_n = 1'b1;
    tick(4);
    check("sel_err_sticky", 16'(sel_err), 16'd1);

    // CCTL disable / enable
    cctl_write(13'h0008);
    check("cctl_rd4_off", 16'(rd4), 16'd0);
    check("cctl_rd5_off", 16'(rd5), 16'd0);
    addr_in = 13'h0000; s4_n = 1'b0;
    tick(8);
    check("disabled_no_oe", 16'(data_oe), 16'd0);
    s4_n = 1'b1;
    tick(3);
    cctl_write(13'h0000);
    check("cctl_rd4_on", 16'(rd4), 16'd1);
    check("cctl_rd5_on", 16'(rd5), 16'd1);

`ifdef CART_BANKSW_EN
    cctl_write(13'h0002);
    addr_in = 13'h0000; s4_n = 1'b0; sb.push_back(8'h5A);
    wait_oe("bank_oe_rise", 1'b1, 8);
    pop_check("bank_data");
    s4_n = 1'b1;
    wait_oe("bank_release", 1'b0, 3);
    tick(2);
    cctl_write(13'h0000);
`endif

    // Reset during DRIVE; ROM contents survive
    addr_in = 13'h0000; s4_n = 1'b0; sb.push_back(8'hA5);
    wait_oe("t6_oe_rise", 1'b1, 8);
    pop_check("t6_data");
    rst = 1'b1;
    tick(1);
    check("t6_rst_oe", 16'(data_oe), 16'd0);
    rst = 1'b0;
    sb.push_back(8'hA5);
    wait_oe("t6_reread_rise", 1'b1, 8);
    pop_check("t6_reread_data");
    s4_n = 1'b1;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
